regfile_write_scheduler: RTL and testbench
==========================================

Name: regfile_write_scheduler

Overview:
- Sole owner of the register file write port (RegWrite / Write_register / Write_Data).
- Arbitrates writeback requests from three sources: ALU result, memory load return, debug/host poke.
- Keeps a 32-entry pending-write scoreboard so the decode stage can stall on RAW hazards until the value is readable from the register file.
- Sits between the writeback stage and the register file; its outputs drive the register file directly.

Parameters:
- STARVE_LIMIT, 4, consecutive blocked cycles after which a MEM or DBG requester is promoted above ALU.
- CNT_W, 3, width of each starvation counter; must hold STARVE_LIMIT.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU writeback request.
- alu_ready  output  1  ALU request granted this cycle.
- alu_addr  input  5  ALU destination register.
- alu_data  input  32  ALU write data.
- mem_valid  input  1  load writeback request.
- mem_ready  output  1  load request granted this cycle.
- mem_addr  input  5  load destination register.
- mem_data  input  32  load write data.
- dbg_valid  input  1  debug write request.
- dbg_ready  output  1  debug request granted this cycle.
- dbg_addr  input  5  debug destination register.
- dbg_data  input  32  debug write data.
- issue_valid  input  1  an instruction with a register destination issues this cycle.
- issue_addr  input  5  destination of the issuing instruction.
- rs_addr  input  5  decode rs to hazard-check.
- rt_addr  input  5  decode rt to hazard-check.
- rs_busy  output  1  rs has an outstanding or in-flight write.
- rt_busy  output  1  rt has an outstanding or in-flight write.
- RegWrite  output  1  register file write enable (registered).
- Write_register  output  5  register file write address (registered).
- Write_Data  output  32  register file write data (registered).

Behaviour:
- Reset (asynchronous): RegWrite=0, Write_register=0, Write_Data=0, pending[31:0]=0, both starvation counters=0. While RESET is high, all ready outputs are 0 and both busy outputs are 0.
- Arbitration is combinational. At most one ready is high per cycle, and only to a requester whose valid is high.
- Default priority: ALU > MEM > DBG.
- Promotion: a requester whose counter equals STARVE_LIMIT ranks above ALU. If both MEM and DBG are promoted, MEM wins.
- Transfer occurs when valid & ready. valid, addr and data must be held stable until ready.
- Starvation counter (MEM and DBG each):
  - Increments when valid=1 and ready=0; saturates at STARVE_LIMIT.
  - Clears on that requester's transfer, or on any cycle its valid=0.
- Write latency: a transfer at edge N produces RegWrite=1 with the winner's addr/data during cycle N+1; the register file commits at edge N+2.
- Writes to addr 0: the transfer completes (ready high), but RegWrite is 0 the next cycle and no pending bit is touched.
- No transfer in a cycle means RegWrite=0 the next cycle. Write_register and Write_Data hold their previous values.
- Scoreboard:
  - issue_valid with issue_addr≠0 sets pending[issue_addr].
  - A transfer with addr≠0 clears pending[addr] at the same edge.
  - Set and clear of the same register at the same edge: set wins, since the newer write is outstanding.
  - Set of an already-set bit is harmless. Clear of a non-pending bit is harmless; a debug write is allowed to clear nothing.
- Busy (combinational), for x in {rs, rt}:
  - x_busy = (x_addr≠0) & (pending[x_addr] | (RegWrite & Write_register==x_addr)).
  - This covers the one cycle when the value is on the write bus but not yet in the register file.
- Reset mid-operation: in-flight RegWrite drops immediately. Pending bits and counters are lost; requesters must re-present after RESET falls.

Test Plan:
- Reset then idle: RESET pulse with all valid=0 → RegWrite=0, Write_register=0, Write_Data=0, busy=0, all ready=0.
- Priority and latency: alu_valid (addr 5, data 0xDEADBEEF) and mem_valid (addr 6, data 0x12345678) asserted together → alu_ready=1 first cycle, next cycle RegWrite=1 / Write_register=5 / Write_Data=0xDEADBEEF; mem_ready=1 the following cycle, then RegWrite=1 / Write_register=6 / Write_Data=0x12345678.
- Starvation promotion: alu_valid held high continuously, dbg_valid high (addr 9) → dbg_ready=0 for 4 cycles, dbg_ready=1 on the 5th cycle, Write_register=9 one cycle later, counter returns to 0.
- Zero register: alu write addr 0, data 0xFFFFFFFF → alu_ready=1, RegWrite stays 0; issue_addr=0 never asserts busy.
- Scoreboard: issue_addr=8, then rs_addr=8 → rs_busy=1 until the mem transfer to 8 completes; rs_busy stays 1 during the RegWrite cycle and clears the cycle after. Issue and transfer to 8 on the same edge → rs_busy remains 1 afterwards.
- Async reset mid-write: RESET asserted between edges while RegWrite=1 → RegWrite=0 immediately, pending cleared, rs_busy=0 without any clock edge.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// ============================================================================
// Module   : regfile_write_scheduler
// Brief    : Register-file write-port arbiter (ALU/MEM/DBG) with RAW scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_scheduler #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    input  logic        dbg_valid,
    output logic        dbg_ready,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        rs_busy,
    output logic        rt_busy,
    output logic        RegWrite,
    output logic [4:0]  Write_register,
    output logic [31:0] Write_Data
);

    localparam logic [CNT_W-1:0] c_limit = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    logic [31:0]      r_pending;
    logic [CNT_W-1:0] r_mem_cnt;
    logic [CNT_W-1:0] r_dbg_cnt;

    logic             w_mem_prom;
    logic             w_dbg_prom;
    logic             w_xfer;
    logic [4:0]       w_addr;
    logic [31:0]      w_data;

    assign w_mem_prom = (r_mem_cnt == c_limit);
    assign w_dbg_prom = (r_dbg_cnt == c_limit);

    // Promoted requesters outrank ALU; MEM beats DBG at either rank.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        dbg_ready = 1'b0;
        if (!RESET) begin
            if (mem_valid && w_mem_prom)
                mem_ready = 1'b1;
            else if (dbg_valid && w_dbg_prom)
                dbg_ready = 1'b1;
            else if (alu_valid)
                alu_ready = 1'b1;
            else if (mem_valid)
                mem_ready = 1'b1;
            else if (dbg_valid)
                dbg_ready = 1'b1;
        end
    end

    always_comb begin
        w_xfer = alu_ready | mem_ready | dbg_ready;
        w_addr = 5'd0;
        w_data = 32'd0;
        if (alu_ready) begin
            w_addr = alu_addr;
            w_data = alu_data;
        end else if (mem_ready) begin
            w_addr = mem_addr;
            w_data = mem_data;
        end else if (dbg_ready) begin
            w_addr = dbg_addr;
            w_data = dbg_data;
        end
    end

    // A write to r0 is accepted but treated as no write at all.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RegWrite       <= 1'b0;
            Write_register <= 5'd0;
            Write_Data     <= 32'd0;
        end else begin
            RegWrite <= w_xfer && (w_addr != 5'd0);
            if (w_xfer && (w_addr != 5'd0)) begin
                Write_register <= w_addr;
                Write_Data     <= w_data;
            end
        end
    end

    // Set is applied after clear so a same-edge reissue stays outstanding.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pending <= 32'd0;
        end else begin
            logic [31:0] v_next;
            v_next = r_pending;
            if (w_xfer && (w_addr != 5'd0))
                v_next[w_addr] = 1'b0;
            if (issue_valid && (issue_addr != 5'd0))
                v_next[issue_addr] = 1'b1;
            r_pending <= v_next;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_mem_cnt <= '0;
            r_dbg_cnt <= '0;
        end else begin
            if (!mem_valid || mem_ready)
                r_mem_cnt <= '0;
            else if (r_mem_cnt != c_limit)
                r_mem_cnt <= r_mem_cnt + c_one;

            if (!dbg_valid || dbg_ready)
                r_dbg_cnt <= '0;
            else if (r_dbg_cnt != c_limit)
                r_dbg_cnt <= r_dbg_cnt + c_one;
        end
    end

    assign rs_busy = (rs_addr != 5'd0) &&
                     (r_pending[rs_addr] || (RegWrite && (Write_register == rs_addr)));
    assign rt_busy = (rt_addr != 5'd0) &&
                     (r_pending[rt_addr] || (RegWrite && (Write_register == rt_addr)));

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: scoreboard of expected register-file writes
// plus direct checks of grants and hazard flags.
`default_nettype none

module tb_regfile_write_scheduler;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0, dbg_valid = 1'b0;
    logic        alu_ready, mem_ready, dbg_ready;
    logic [4:0]  alu_addr = '0, mem_addr = '0, dbg_addr = '0;
    logic [31:0] alu_data = '0, mem_data = '0, dbg_data = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_addr = '0, rs_addr = '0, rt_addr = '0;
    logic        rs_busy, rt_busy;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_Data;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    regfile_write_scheduler #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .CLK(CLK), .RESET(RESET),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .RegWrite(RegWrite), .Write_register(Write_register), .Write_Data(Write_Data)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_ready(input string tag, input logic a, input logic m, input logic d);
        chk({tag, "_alu_rdy"}, {31'd0, alu_ready}, {31'd0, a});
        chk({tag, "_mem_rdy"}, {31'd0, mem_ready}, {31'd0, m});
        chk({tag, "_dbg_rdy"}, {31'd0, dbg_ready}, {31'd0, d});
    endtask

    // Every register-file write must match the oldest expected entry.
    always @(negedge CLK) begin
        if (RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {27'd0, Write_register}, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {27'd0, Write_register}, {27'd0, e.addr});
                chk("wr_data", Write_Data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        // Reset then idle
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_wreg", {27'd0, Write_register}, 32'd0);
        chk("rst_wdata", Write_Data, 32'd0);
        chk_ready("rst", 1'b0, 1'b0, 1'b0);
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        chk("idle_rs_busy", {31'd0, rs_busy}, 32'd0);
        chk_ready("idle", 1'b0, 1'b0, 1'b0);

        // Priority and latency: ALU beats MEM, MEM follows one cycle later
        tick();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 32'h12345678;
        exp_q.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
        exp_q.push_back('{addr: 5'd6, data: 32'h12345678});
        @(negedge CLK);
        chk_ready("prio0", 1'b1, 1'b0, 1'b0);
        tick();
        alu_valid = 1'b0;
        @(negedge CLK);
        chk_ready("prio1", 1'b0, 1'b1, 1'b0);
        chk("prio1_regwrite", {31'd0, RegWrite}, 32'd1);
        tick();
        mem_valid = 1'b0;
        @(negedge CLK);
        chk("prio2_regwrite", {31'd0, RegWrite}, 32'd1);
        tick();
        @(negedge CLK);
        chk("prio3_regwrite", {31'd0, RegWrite}, 32'd0);

        // Starvation: DBG promoted after four blocked cycles
        tick();
        dbg_valid = 1'b1; dbg_addr = 5'd9; dbg_data = 32'h0BADF00D;
        alu_valid = 1'b1; alu_addr = 5'd3;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                alu_data = 32'h100 + i;
                exp_q.push_back('{addr: 5'd3, data: alu_data});
            end else begin
                exp_q.push_back('{addr: 5'd9, data: 32'h0BADF00D});
            end
            @(negedge CLK);
            chk_ready($sformatf("starve%0d", i), i != 4, 1'b0, i == 4);
            tick();
        end
        dbg_valid = 1'b0;
        exp_q.push_back('{addr: 5'd3, data: alu_data});
        @(negedge CLK);
        chk_ready("starve5", 1'b1, 1'b0, 1'b0);
        tick();
        // Counter must be back at 0: a fresh DBG request loses to ALU
        dbg_valid = 1'b1; dbg_addr = 5'd11; dbg_data = 32'h0000D00D;
        alu_data = 32'h200;
        exp_q.push_back('{addr: 5'd3, data: 32'h200});
        exp_q.push_back('{addr: 5'd11, data: 32'h0000D00D});
        @(negedge CLK);
        chk_ready("restart0", 1'b1, 1'b0, 1'b0);
        tick();
        alu_valid = 1'b0;
        @(negedge CLK);
        chk_ready("restart1", 1'b0, 1'b0, 1'b1);
        tick();
        dbg_valid = 1'b0;
        tick();

        // Zero register: accepted, never written, never busy
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFFFFFF;
        issue_valid = 1'b1; issue_addr = 5'd0;
        @(negedge CLK);
        chk_ready("zero", 1'b1, 1'b0, 1'b0);
        tick();
        alu_valid = 1'b0; issue_valid = 1'b0;
        @(negedge CLK);
        chk("zero_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("zero_rs_busy", {31'd0, rs_busy}, 32'd0);

        // Scoreboard: issue to r8, clear via MEM transfer
        tick();
        issue_valid = 1'b1; issue_addr = 5'd8; rs_addr = 5'd8;
        @(negedge CLK);
        chk("sb_pre_busy", {31'd0, rs_busy}, 32'd0);
        tick();
        issue_valid = 1'b0;
        @(negedge CLK);
        chk("sb_set_busy", {31'd0, rs_busy}, 32'd1);
        tick();
        mem_valid = 1'b1; mem_addr = 5'd8; mem_data = 32'hA5A5A5A5;
        exp_q.push_back('{addr: 5'd8, data: 32'hA5A5A5A5});
        @(negedge CLK);
        chk("sb_xfer_rdy", {31'd0, mem_ready}, 32'd1);
        chk("sb_xfer_busy", {31'd0, rs_busy}, 32'd1);
        tick();
        mem_valid = 1'b0;
        @(negedge CLK);
        chk("sb_wb_busy", {31'd0, rs_busy}, 32'd1);
        tick();
        @(negedge CLK);
        chk("sb_clear_busy", {31'd0, rs_busy}, 32'd0);

        // Same-edge issue and transfer to r8: set wins
        tick();
        issue_valid = 1'b1; issue_addr = 5'd8; rt_addr = 5'd8;
        mem_valid = 1'b1; mem_addr = 5'd8; mem_data = 32'h5A5A5A5A;
        exp_q.push_back('{addr: 5'd8, data: 32'h5A5A5A5A});
        tick();
        issue_valid = 1'b0; mem_valid = 1'b0;
        tick();
        @(negedge CLK);
        chk("same_rs_busy", {31'd0, rs_busy}, 32'd1);
        chk("same_rt_busy", {31'd0, rt_busy}, 32'd1);

        // Async reset during a write-bus cycle
        tick();
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'h00000077;
        exp_q.push_back('{addr: 5'd10, data: 32'h00000077});
        tick();
        alu_valid = 1'b0;
        @(negedge CLK);
        chk("ar_regwrite_pre", {31'd0, RegWrite}, 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        chk("ar_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("ar_rs_busy", {31'd0, rs_busy}, 32'd0);
        chk("ar_rt_busy", {31'd0, rt_busy}, 32'd0);
        tick();
        RESET = 1'b0;

        // Post-reset: lone DBG request granted immediately
        dbg_valid = 1'b1; dbg_addr = 5'd12; dbg_data = 32'hCAFEF00D;
        exp_q.push_back('{addr: 5'd12, data: 32'hCAFEF00D});
        @(negedge CLK);
        chk_ready("post_rst", 1'b0, 1'b0, 1'b1);
        chk("post_rst_rs_busy", {31'd0, rs_busy}, 32'd0);
        tick();
        dbg_valid = 1'b0;
        repeat (3) tick();
        @(negedge CLK);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
